// File: rtl/mem_arbiter_pkg.sv
// Shared RISC-V core types: ALU opcodes plus the instruction/data memory arbiter
// state and owner encodings.
package mem_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_e;

  typedef enum logic {
    OWNER_IFU,
    OWNER_LSU
  } arb_owner_e;

  localparam int ARB_CNT_W = 8;

  // On a tie the requester that did not win last time goes next.
  function automatic arb_owner_e pick_owner(input logic ifu_req,
                                            input logic lsu_req,
                                            input arb_owner_e last_owner);
    arb_owner_e winner;
    if (ifu_req && lsu_req) begin
      winner = (last_owner == OWNER_IFU) ? OWNER_LSU : OWNER_IFU;
    end else if (lsu_req) begin
      winner = OWNER_LSU;
    end else begin
      winner = OWNER_IFU;
    end
    return winner;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single memory port with one
// outstanding transaction, round-robin tie break and a response timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_gnt,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [ARB_CNT_W-1:0] TIMEOUT_CNT = ARB_CNT_W'(TIMEOUT);

  arb_state_e           state_reg;
  arb_owner_e           owner_reg;
  arb_owner_e           last_owner_reg;
  arb_owner_e           owner_next;
  logic [ARB_CNT_W-1:0] cnt_reg;
  logic                 resp_fire;

  assign owner_next = pick_owner(ifu_req, lsu_req, last_owner_reg);
  assign resp_fire  = mem_rvalid || (cnt_reg == TIMEOUT_CNT);

  // Grant is the memory handshake itself, so it follows mem_ready in the same cycle.
  assign ifu_gnt = (state_reg == REQ) && mem_ready && (owner_reg == OWNER_IFU);
  assign lsu_gnt = (state_reg == REQ) && mem_ready && (owner_reg == OWNER_LSU);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= OWNER_IFU;
      last_owner_reg <= OWNER_IFU;
      cnt_reg        <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      ifu_rvalid     <= 1'b0;
      ifu_rdata      <= '0;
      ifu_err        <= 1'b0;
      lsu_rvalid     <= 1'b0;
      lsu_rdata      <= '0;
      lsu_err        <= 1'b0;
    end else begin
      ifu_rvalid <= 1'b0;
      ifu_rdata  <= '0;
      ifu_err    <= 1'b0;
      lsu_rvalid <= 1'b0;
      lsu_rdata  <= '0;
      lsu_err    <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (ifu_req || lsu_req) begin
            owner_reg <= owner_next;
            state_reg <= REQ;
            mem_req   <= 1'b1;
            if (owner_next == OWNER_LSU) begin
              mem_we    <= lsu_we;
              mem_addr  <= lsu_addr;
              mem_wdata <= lsu_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= ifu_addr;
              mem_wdata <= '0;
            end
          end
        end

        REQ: begin
          if (mem_ready) begin
            last_owner_reg <= owner_reg;
            cnt_reg        <= '0;
            state_reg      <= WAIT;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
          end
        end

        WAIT: begin
          // A real response beats a timeout landing in the same cycle.
          if (resp_fire) begin
            state_reg <= IDLE;
            if (owner_reg == OWNER_LSU) begin
              lsu_rvalid <= 1'b1;
              lsu_rdata  <= mem_rvalid ? mem_rdata : '0;
              lsu_err    <= !mem_rvalid;
            end else begin
              ifu_rvalid <= 1'b1;
              ifu_rdata  <= mem_rvalid ? mem_rdata : '0;
              ifu_err    <= !mem_rvalid;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// transactions scored against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req, ifu_gnt, ifu_rvalid, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;
  int last_win = 0;  // 0 = IFU, 1 = LSU

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ifu_gnt"},    ifu_gnt,    0);
    check({tag, "_lsu_gnt"},    lsu_gnt,    0);
    check({tag, "_ifu_rvalid"}, ifu_rvalid, 0);
    check({tag, "_lsu_rvalid"}, lsu_rvalid, 0);
    check({tag, "_mem_req"},    mem_req,    0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ifu_req = 0; lsu_req = 0; mem_ready = 0; mem_rvalid = 0;
    tick();
    rst_n = 1'b1;
    last_win = 0;
    settle();
    check_quiet("reset");
    check("reset_ifu_rdata", ifu_rdata, 0);
    check("reset_lsu_err",   lsu_err,   0);
    check("reset_mem_addr",  mem_addr,  0);
  endtask

  // One complete transaction. rdly = cycles mem_ready is held low;
  // rcyc = WAIT cycle (1-based) carrying mem_rvalid, beyond TMO+1 means none.
  task automatic run_txn(input bit ir, input bit lr, input bit we,
                         input logic [31:0] ia, input logic [31:0] la,
                         input logic [31:0] wd, input int rdly, input int rcyc,
                         input logic [31:0] rdat);
    int win;
    bit tmo;
    logic [31:0] ea, ew, ewe;
    if (ir && lr) win = (last_win == 0) ? 1 : 0;
    else          win = lr ? 1 : 0;
    ea  = win ? la : ia;
    ew  = win ? wd : 32'h0;
    ewe = win ? {31'h0, we} : 32'h0;
    tmo = (rcyc < 1) || (rcyc > TMO + 1);

    ifu_req = ir; ifu_addr = ia; lsu_req = lr; lsu_we = we; lsu_addr = la; lsu_wdata = wd;
    mem_ready = 0; mem_rvalid = 0;
    settle();
    check("idle_mem_req", mem_req, 0);
    tick();

    for (int i = 0; i <= rdly; i++) begin
      mem_ready = (i == rdly);
      settle();
      check("req_mem_req",   mem_req,   1);
      check("req_mem_addr",  mem_addr,  ea);
      check("req_mem_wdata", mem_wdata, ew);
      check("req_mem_we",    mem_we,    ewe);
      check("req_ifu_gnt",   ifu_gnt,   (win == 0 && i == rdly) ? 1 : 0);
      check("req_lsu_gnt",   lsu_gnt,   (win == 1 && i == rdly) ? 1 : 0);
      tick();
    end
    last_win = win;

    // Scramble requester buses after the grant; they must not be sampled.
    ifu_req = 0; lsu_req = 0; mem_ready = 0;
    ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom;
    for (int k = 1; k <= TMO + 1; k++) begin
      mem_rvalid = (k == rcyc);
      mem_rdata  = (k == rcyc) ? rdat : $urandom;
      settle();
      check("wait_mem_req",    mem_req,    0);
      check("wait_ifu_rvalid", ifu_rvalid, 0);
      check("wait_lsu_rvalid", lsu_rvalid, 0);
      tick();
      if (k == rcyc) break;
    end

    // After a timeout, push a late response into IDLE; it must be ignored.
    mem_rvalid = tmo;
    mem_rdata  = $urandom;
    settle();
    check("resp_ifu_rvalid", ifu_rvalid, (win == 0) ? 1 : 0);
    check("resp_lsu_rvalid", lsu_rvalid, (win == 1) ? 1 : 0);
    check("resp_ifu_rdata",  ifu_rdata,  (win == 0 && !tmo) ? rdat : 0);
    check("resp_lsu_rdata",  lsu_rdata,  (win == 1 && !tmo) ? rdat : 0);
    check("resp_ifu_err",    ifu_err,    (win == 0 && tmo) ? 1 : 0);
    check("resp_lsu_err",    lsu_err,    (win == 1 && tmo) ? 1 : 0);
    $display("txn owner=%s we=%0b addr=0x%08h rdly=%0d rcyc=%0d timeout=%0b",
             win ? "LSU" : "IFU", ewe[0], ea, rdly, rcyc, tmo);
    tick();
    mem_rvalid = 0;
    settle();
    check_quiet("post");
  endtask

  initial begin
    ifu_addr = 0; lsu_we = 0; lsu_addr = 0; lsu_wdata = 0; mem_rdata = 0;
    do_reset();

    // Basic fetch, minimum latency.
    run_txn(1, 0, 0, 32'h10, 32'h0, 32'h0, 0, 1, 32'h13);
    // Store held off by mem_ready while the fetch port also requests.
    run_txn(1, 1, 1, 32'h44, 32'h100, 32'hDEADBEEF, 3, 1, 32'h0);

    // Round robin from reset: LSU, IFU, LSU.
    do_reset();
    run_txn(1, 1, 0, 32'h200, 32'h300, 32'h0, 0, 1, 32'hA1);
    run_txn(1, 1, 0, 32'h204, 32'h304, 32'h0, 0, 2, 32'hA2);
    run_txn(1, 1, 0, 32'h208, 32'h308, 32'h0, 0, 1, 32'hA3);

    // Timeout with no response, then response on the exact timeout cycle.
    run_txn(0, 1, 0, 32'h0, 32'h400, 32'h0, 0, 99, 32'h0);
    run_txn(1, 0, 0, 32'h500, 32'h0, 32'h0, 1, TMO + 1, 32'h55);

    // Reset during WAIT abandons the transaction; a stray response is ignored.
    ifu_req = 1; ifu_addr = 32'h600; mem_ready = 1;
    tick();
    tick();
    ifu_req = 0; mem_ready = 0;
    rst_n = 0;
    tick();
    rst_n = 1; last_win = 0;
    mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    settle();
    check_quiet("rst_wait");
    tick();
    mem_rvalid = 0;
    settle();
    check_quiet("rst_stray");
    run_txn(1, 0, 0, 32'h604, 32'h0, 32'h0, 0, 1, 32'h77);

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      bit ir, lr;
      ir = $urandom_range(0, 1);
      lr = $urandom_range(0, 1);
      if (!ir && !lr) ir = 1;
      run_txn(ir, lr, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(1, TMO + 3), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, sets the number of WAIT cycles without mem_rvalid before a timeout response (range 1..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 ifu_req  in  1  fetch request; ifu_addr in 32 word address; ifu_gnt out 1 request accepted pulse.
REQ-005 ifu_rvalid  out  1  fetch response pulse; ifu_rdata out 32 read data; ifu_err out 1 timeout flag, valid with ifu_rvalid.
REQ-006 lsu_req  in  1  load/store request; lsu_we in 1 write enable; lsu_addr in 32; lsu_wdata in 32; lsu_gnt out 1 accepted pulse.
REQ-007 lsu_rvalid  out  1  load/store response pulse, also for writes; lsu_rdata out 32; lsu_err out 1 timeout flag.
REQ-008 mem_req  out  1  memory request; mem_we out 1; mem_addr out 32; mem_wdata out 32.
REQ-009 mem_ready  in  1  memory accepts mem_req this cycle; mem_rvalid in 1 response; mem_rdata in 32.

Function
REQ-010 The FSM SHALL have states IDLE, REQ, WAIT plus registers owner (IFU/LSU), last_owner, and an 8-bit wait counter.
REQ-011 IDLE: on ifu_req or lsu_req, latch owner and go to REQ next cycle; otherwise stay in IDLE.
REQ-012 Tie (both requests in IDLE): owner = the requester not equal to last_owner (round robin); single request: that requester wins.
REQ-013 REQ: mem_req=1, mem_we/addr/wdata driven from owner (mem_we=0 for IFU); on mem_ready=1 pulse owner gnt for that cycle, set last_owner=owner, clear counter, go to WAIT.
REQ-014 REQ with mem_ready=0 SHALL hold mem_req and the owner; the other requester is never granted meanwhile.
REQ-015 Requesters SHALL hold req, addr, we and wdata stable until gnt; the arbiter SHALL NOT sample them after gnt.
REQ-016 WAIT: mem_req=0; on mem_rvalid=1 drive owner rvalid=1, rdata=mem_rdata, err=0 for one cycle, go to IDLE.
REQ-017 WAIT without mem_rvalid: counter increments; when counter==TIMEOUT, owner rvalid=1, err=1, rdata=0, go to IDLE.
REQ-018 mem_rvalid in the same cycle as the timeout condition takes precedence (normal response, err=0).
REQ-019 mem_rvalid arriving in IDLE or REQ SHALL be ignored (late or stray response).
REQ-020 Outside REQ-013/016/017, all gnt, rvalid and err outputs are 0, rdata outputs are 0, and mem_addr/wdata/we are 0.
REQ-021 Minimum latency: req seen in IDLE -> gnt 1 cycle later (mem_ready=1) -> rvalid 1 cycle after mem_rvalid; min 1 idle cycle between transactions.
REQ-022 At most one transaction is outstanding at any time.

Reset
REQ-023 With rst_n=0 at a clock edge: state=IDLE, owner=IFU, last_owner=IFU (first tie goes to LSU), counter=0, and all outputs 0 the following cycle.
REQ-024 Reset mid-transaction SHALL abandon it without any rvalid; a subsequent stray mem_rvalid is ignored per REQ-019.

Structure
REQ-025 The arb_state_e (IDLE/REQ/WAIT) and arb_owner_e (OWNER_IFU/OWNER_LSU) enums SHALL live in the shared riscv types package alongside alu_op_e.
REQ-026 A single flat module; no sub-module is required. The timeout counter width is fixed at 8 bits.

Verification
REQ-027 After reset, ifu_req=1, addr=0x0000_0010, mem_ready=1, mem_rvalid one cycle after gnt with rdata=0x0000_0013 -> ifu_gnt in cycle 1 and ifu_rvalid=1 with rdata=0x0000_0013, err=0.
REQ-028 Both requests asserted after reset, then again -> first grant LSU, second IFU, third LSU.
REQ-029 lsu_we=1, addr=0x100, wdata=0xDEADBEEF, mem_ready low 3 cycles -> mem_req held 4 cycles with stable addr/wdata, lsu_gnt only in the 4th cycle, and no ifu_gnt despite ifu_req=1.
REQ-030 TIMEOUT=4, no mem_rvalid -> owner rvalid=1, err=1, rdata=0 on the 5th WAIT cycle; a later mem_rvalid produces no response.
REQ-031 Drop rst_n during WAIT, then mem_rvalid=1 -> no rvalid on either port; state is IDLE and the next request is served normally.
REQ-032 TIMEOUT=4 with mem_rvalid on the exact timeout cycle and rdata=0x55 -> rvalid with rdata=0x55, err=0.
